// File: rtl/riscy_pkg.sv
// ---------------------------------------------------------------------------
// riscy_pkg
// Shared definitions for the decode-stage load/store-multiple sequencer:
// datapath and register-list widths plus the sequencer state type.
// No ports (package).
// ---------------------------------------------------------------------------
package riscy_pkg;

   localparam int ADDR_W = 16;
   localparam int LIST_W = 8;
   localparam int REG_AW = 3;

   // Sequencer is either waiting for an LM/SM or expanding one into micro-ops
   typedef enum logic {
      IDLE = 1'b0,
      SEQ  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/lm_sm_sequencer_lsb_prio_enc.sv
// ---------------------------------------------------------------------------
// lsb_prio_enc
// Lowest-set-bit priority encoder used to walk a register list from
// register 0 upward.
// Ports:
//   i_mask    in   LIST_W  remaining register list
//   o_index   out  REG_AW  index of the lowest set bit (0 when mask is 0)
//   o_onehot  out  LIST_W  one-hot mask of that bit, used to clear it
//   o_single  out  1       mask has exactly one bit set
// ---------------------------------------------------------------------------
module lsb_prio_enc
   import riscy_pkg::*;
#(
   parameter int P_LIST_W = LIST_W,
   parameter int P_REG_AW = REG_AW
) (
   input  logic [P_LIST_W-1:0] i_mask,
   output logic [P_REG_AW-1:0] o_index,
   output logic [P_LIST_W-1:0] o_onehot,
   output logic                o_single
);

   logic [P_LIST_W-1:0] w_minus_one;

   // Scan from the top down so the last hit written is the lowest set bit
   always_comb begin
      o_index = '0;
      for (int i = P_LIST_W - 1; i >= 0; i--) begin
         if (i_mask[i]) begin
            o_index = P_REG_AW'(i);
         end
      end
   end

   // Two's-complement trick isolates the lowest set bit; removing it and
   // finding nothing left means exactly one bit was set
   assign w_minus_one = i_mask - P_LIST_W'(1);
   assign o_onehot    = i_mask & (~i_mask + P_LIST_W'(1));
   assign o_single    = (i_mask != '0) && ((i_mask & w_minus_one) == '0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer
// Expands an LM/SM instruction with an 8-bit register list into one
// single-register micro-op per set bit, lowest register first, and holds
// the front end (PC, IF/ID) while the expansion is in progress.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   valid_in     decode stage holds a valid instruction
//   is_lm_in     instruction is LM (wins if is_sm_in is also set)
//   is_sm_in     instruction is SM
//   reg_list     register list, bit i selects register i
//   stall        downstream stall, freezes the sequencer
//   flush        decode flush, aborts any sequence
//   sel_seq      decode mux takes sequencer fields
//   hold_front   hold PC and IF/ID this cycle
//   busy         a sequence is in progress
//   uop_valid    a micro-op is presented
//   uop_reg      register address of the micro-op
//   uop_offset   word offset from base (micro-op index)
//   uop_is_lm    micro-op belongs to an LM
//   uop_is_sm    micro-op belongs to an SM
//   uop_last     final micro-op of the sequence
// ---------------------------------------------------------------------------
module lm_sm_sequencer
   import riscy_pkg::*;
#(
   parameter int ADDR_W = riscy_pkg::ADDR_W,
   parameter int LIST_W = riscy_pkg::LIST_W,
   parameter int REG_AW = riscy_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              is_lm_in,
   input  logic              is_sm_in,
   input  logic [LIST_W-1:0] reg_list,
   input  logic              stall,
   input  logic              flush,
   output logic              sel_seq,
   output logic              hold_front,
   output logic              busy,
   output logic              uop_valid,
   output logic [REG_AW-1:0] uop_reg,
   output logic [ADDR_W-1:0] uop_offset,
   output logic              uop_is_lm,
   output logic              uop_is_sm,
   output logic              uop_last
);

   seq_state_t        r_state;
   logic [LIST_W-1:0] r_mask;
   logic [REG_AW:0]   r_cnt;
   logic              r_kind_lm;
   logic              r_kind_sm;

   seq_state_t        w_nxt_state;
   logic [LIST_W-1:0] w_nxt_mask;
   logic [REG_AW:0]   w_nxt_cnt;
   logic              w_nxt_lm;
   logic              w_nxt_sm;

   logic              w_is_multi;
   logic              w_accept;
   logic [REG_AW-1:0] w_enc_index;
   logic [LIST_W-1:0] w_enc_onehot;
   logic              w_enc_single;

   lsb_prio_enc #(
      .P_LIST_W (LIST_W),
      .P_REG_AW (REG_AW)
   ) u_enc (
      .i_mask   (r_mask),
      .o_index  (w_enc_index),
      .o_onehot (w_enc_onehot),
      .o_single (w_enc_single)
   );

   // An empty register list is never accepted; it retires as a NOP instead
   assign w_is_multi = valid_in & (is_lm_in | is_sm_in);
   assign w_accept   = (r_state == IDLE) & w_is_multi & (reg_list != '0)
                       & ~stall & ~flush;
   assign busy       = (r_state == SEQ);

   // State register; everything else is decided in the combinational block
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mask    <= '0;
         r_cnt     <= '0;
         r_kind_lm <= 1'b0;
         r_kind_sm <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_mask    <= w_nxt_mask;
         r_cnt     <= w_nxt_cnt;
         r_kind_lm <= w_nxt_lm;
         r_kind_sm <= w_nxt_sm;
      end
   end

   // Next-state and output decode. In SEQ the micro-op fields come purely
   // from registered state, so a stall simply re-presents the same micro-op.
   // Flush is applied last so it overrides both accept and advance.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_mask  = r_mask;
      w_nxt_cnt   = r_cnt;
      w_nxt_lm    = r_kind_lm;
      w_nxt_sm    = r_kind_sm;
      sel_seq     = 1'b0;
      hold_front  = 1'b0;
      uop_valid   = 1'b0;
      uop_reg     = '0;
      uop_offset  = '0;
      uop_is_lm   = 1'b0;
      uop_is_sm   = 1'b0;
      uop_last    = 1'b0;

      case (r_state)
         IDLE: begin
            sel_seq    = w_is_multi;
            hold_front = w_accept;
            if (w_accept) begin
               w_nxt_state = SEQ;
               w_nxt_mask  = reg_list;
               w_nxt_cnt   = '0;
               w_nxt_lm    = is_lm_in;
               w_nxt_sm    = is_sm_in & ~is_lm_in;
            end
         end
         SEQ: begin
            sel_seq    = 1'b1;
            uop_valid  = ~flush;
            uop_reg    = w_enc_index;
            uop_offset = ADDR_W'(r_cnt);
            uop_is_lm  = r_kind_lm;
            uop_is_sm  = r_kind_sm;
            uop_last   = w_enc_single;
            hold_front = ~w_enc_single;
            if (!stall) begin
               w_nxt_mask = r_mask & ~w_enc_onehot;
               w_nxt_cnt  = r_cnt + 1'b1;
               if (w_enc_single) begin
                  w_nxt_state = IDLE;
               end
            end
         end
         default: begin
            w_nxt_state = IDLE;
         end
      endcase

      if (flush) begin
         w_nxt_state = IDLE;
         w_nxt_mask  = '0;
         w_nxt_cnt   = '0;
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lm_sm_sequencer
// Directed scenarios with literal expectations, then randomized traffic.
// A queue-based reference model (list of registers still to issue) predicts
// every output on every cycle; a compare process checks it at each negedge.
// ---------------------------------------------------------------------------
module tb_lm_sm_sequencer;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic        is_lm_in;
   logic        is_sm_in;
   logic [7:0]  reg_list;
   logic        stall;
   logic        flush;
   logic        sel_seq;
   logic        hold_front;
   logic        busy;
   logic        uop_valid;
   logic [2:0]  uop_reg;
   logic [15:0] uop_offset;
   logic        uop_is_lm;
   logic        uop_is_sm;
   logic        uop_last;

   int totalChecks = 0;
   int badChecks   = 0;

   // Reference model state: registers still to be issued, in issue order
   bit mBusy = 1'b0;
   int mQ[$];
   int mOff  = 0;
   bit mLm   = 1'b0;
   bit mSm   = 1'b0;

   lm_sm_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .is_lm_in   (is_lm_in),
      .is_sm_in   (is_sm_in),
      .reg_list   (reg_list),
      .stall      (stall),
      .flush      (flush),
      .sel_seq    (sel_seq),
      .hold_front (hold_front),
      .busy       (busy),
      .uop_valid  (uop_valid),
      .uop_reg    (uop_reg),
      .uop_offset (uop_offset),
      .uop_is_lm  (uop_is_lm),
      .uop_is_sm  (uop_is_sm),
      .uop_last   (uop_last)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge (or reset) using the sequencing rules
   task automatic modelStep();
      if (rst) begin
         mBusy = 1'b0;
         mQ.delete();
         mOff  = 0;
         mLm   = 1'b0;
         mSm   = 1'b0;
      end else if (flush) begin
         mBusy = 1'b0;
         mQ.delete();
         mOff  = 0;
      end else if (!mBusy) begin
         if (valid_in && (is_lm_in || is_sm_in) && reg_list != 8'd0 && !stall) begin
            mQ.delete();
            for (int i = 0; i < 8; i++) begin
               if (reg_list[i]) mQ.push_back(i);
            end
            mBusy = 1'b1;
            mOff  = 0;
            mLm   = is_lm_in;
            mSm   = is_sm_in && !is_lm_in;
         end
      end else if (!stall) begin
         void'(mQ.pop_front());
         mOff++;
         if (mQ.size() == 0) mBusy = 1'b0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         modelStep();
      end
   end

   // Compare every output with the model's prediction for this cycle
   task automatic compareAll();
      bit expAccept;
      int expReg;
      expAccept = !mBusy && valid_in && (is_lm_in || is_sm_in) && reg_list != 8'd0
                  && !stall && !flush;
      expReg    = mBusy ? mQ[0] : 0;
      checkOutput("m_busy",       32'(busy),       32'(mBusy));
      checkOutput("m_uop_valid",  32'(uop_valid),  32'(mBusy && !flush));
      checkOutput("m_sel_seq",    32'(sel_seq),    32'(mBusy || (valid_in && (is_lm_in || is_sm_in))));
      checkOutput("m_hold_front", 32'(hold_front), 32'(expAccept || (mBusy && mQ.size() > 1)));
      checkOutput("m_uop_reg",    32'(uop_reg),    32'(expReg));
      checkOutput("m_uop_offset", 32'(uop_offset), mBusy ? 32'(mOff) : 32'd0);
      checkOutput("m_uop_is_lm",  32'(uop_is_lm),  32'(mBusy && mLm));
      checkOutput("m_uop_is_sm",  32'(uop_is_sm),  32'(mBusy && mSm));
      checkOutput("m_uop_last",   32'(uop_last),   32'(mBusy && mQ.size() == 1));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) compareAll();
      end
   end

   // Drive one cycle of inputs just after a posedge, return at the negedge
   task automatic applyStimulus(input logic v, input logic lm, input logic sm,
                                input logic [7:0] lst, input logic st,
                                input logic fl);
      @(posedge clk);
      #1;
      valid_in = v;
      is_lm_in = lm;
      is_sm_in = sm;
      reg_list = lst;
      stall    = st;
      flush    = fl;
      @(negedge clk);
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic checkUop(input string tag, input int r, input int off,
                           input logic last);
      checkOutput({tag, "_valid"},  32'(uop_valid),  32'd1);
      checkOutput({tag, "_reg"},    32'(uop_reg),    32'(r));
      checkOutput({tag, "_offset"}, 32'(uop_offset), 32'(off));
      checkOutput({tag, "_last"},   32'(uop_last),   32'(last));
   endtask

   initial begin
      logic [7:0] rndList;
      rst      = 1'b1;
      valid_in = 1'b0;
      is_lm_in = 1'b0;
      is_sm_in = 1'b0;
      reg_list = 8'h00;
      stall    = 1'b0;
      flush    = 1'b0;

      // Reset state before any clock edge
      #1;
      checkOutput("rst_busy",      32'(busy),       32'd0);
      checkOutput("rst_uop_valid", 32'(uop_valid),  32'd0);
      checkOutput("rst_hold",      32'(hold_front), 32'd0);
      checkOutput("rst_sel",       32'(sel_seq),    32'd0);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: LM 1010_0101 -> regs 0,2,5,7, offsets 0..3
      applyStimulus(1'b1, 1'b1, 1'b0, 8'b1010_0101, 1'b0, 1'b0);
      checkOutput("t1_acc_valid", 32'(uop_valid),  32'd0);
      checkOutput("t1_acc_hold",  32'(hold_front), 32'd1);
      checkOutput("t1_acc_sel",   32'(sel_seq),    32'd1);
      applyIdle();
      checkUop("t1_u0", 0, 0, 1'b0);
      checkOutput("t1_u0_hold", 32'(hold_front), 32'd1);
      checkOutput("t1_u0_islm", 32'(uop_is_lm),  32'd1);
      applyIdle();
      checkUop("t1_u1", 2, 1, 1'b0);
      applyIdle();
      checkUop("t1_u2", 5, 2, 1'b0);
      checkOutput("t1_u2_hold", 32'(hold_front), 32'd1);
      applyIdle();
      checkUop("t1_u3", 7, 3, 1'b1);
      checkOutput("t1_u3_hold", 32'(hold_front), 32'd0);
      applyIdle();
      checkOutput("t1_end_busy", 32'(busy), 32'd0);

      // 2: SM with empty list retires as a NOP
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checkOutput("t2_sel",   32'(sel_seq),    32'd1);
      checkOutput("t2_hold",  32'(hold_front), 32'd0);
      checkOutput("t2_valid", 32'(uop_valid),  32'd0);
      applyIdle();
      checkOutput("t2_busy",  32'(busy),       32'd0);

      // 3: SM 0x80 with two stalled cycles
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkUop("t3_s0", 7, 0, 1'b1);
      checkOutput("t3_s0_issm", 32'(uop_is_sm), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkUop("t3_s1", 7, 0, 1'b1);
      applyIdle();
      checkUop("t3_s2", 7, 0, 1'b1);
      applyIdle();
      checkOutput("t3_end_busy", 32'(busy), 32'd0);

      // 4: LM 0xFF flushed on the second micro-op
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      applyIdle();
      checkUop("t4_u0", 0, 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("t4_flush_valid", 32'(uop_valid), 32'd0);
      applyIdle();
      checkOutput("t4_after_busy",  32'(busy),      32'd0);
      checkOutput("t4_after_valid", 32'(uop_valid), 32'd0);

      // 5: asynchronous reset in the middle of a sequence
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0);
      applyIdle();
      applyIdle();
      checkUop("t5_u1", 1, 1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5_busy",   32'(busy),       32'd0);
      checkOutput("t5_valid",  32'(uop_valid),  32'd0);
      checkOutput("t5_hold",   32'(hold_front), 32'd0);
      checkOutput("t5_sel",    32'(sel_seq),    32'd0);
      checkOutput("t5_last",   32'(uop_last),   32'd0);
      checkOutput("t5_reg",    32'(uop_reg),    32'd0);
      checkOutput("t5_offset", 32'(uop_offset), 32'd0);
      checkOutput("t5_islm",   32'(uop_is_lm),  32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      applyIdle();
      checkOutput("t5_post_busy", 32'(busy), 32'd0);

      // 6: LM 0xFF then SM 0x03 accepted right after the last LM micro-op
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
         checkUop("t6_lm", k, k, (k == 7));
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
      checkOutput("t6_acc_busy", 32'(busy),       32'd0);
      checkOutput("t6_acc_hold", 32'(hold_front), 32'd1);
      applyIdle();
      checkUop("t6_sm0", 0, 0, 1'b0);
      checkOutput("t6_sm0_issm", 32'(uop_is_sm), 32'd1);
      applyIdle();
      checkUop("t6_sm1", 1, 1, 1'b1);

      // 7: both kind bits set -> treated as LM
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
      applyIdle();
      checkUop("t7_u0", 0, 0, 1'b1);
      checkOutput("t7_islm", 32'(uop_is_lm), 32'd1);
      checkOutput("t7_issm", 32'(uop_is_sm), 32'd0);
      applyIdle();

      // Randomized traffic, checked cycle by cycle against the model
      for (int n = 0; n < 1500; n++) begin
         rndList = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) rndList = 8'h00;
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), rndList,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      end
      applyIdle();
      applyIdle();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
